hazard_scheduler: RTL and testbench

HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

---
 rtl/hazard_scheduler.sv | 143 ++++++++++++++
 tb/tb_hazard_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scheduler.sv
// Hazard scheduler for a 5-stage in-order pipeline.
// Keeps a shadow copy of the EX and MEM stage instruction fields. It uses this
// copy to decide whether the instruction in ID must stall on a data hazard,
// whether a taken branch squashes the front end, and whether the whole pipe
// must freeze while the data memory is busy.
module hazard_scheduler #(
    parameter int unsigned FORWARD_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [3:0] src1,
    input  logic [3:0] src2,
    input  logic       two_src,
    input  logic [3:0] id_dest,
    input  logic       id_wb_en,
    input  logic       id_mem_r_en,
    input  logic       id_mem_w_en,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       freeze_pc,
    output logic       freeze_if_id,
    output logic       bubble_ex,
    output logic       freeze_pipe,
    output logic       flush,
    output logic [1:0] state,
    output logic [7:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HAZ_STALL = 2'd1,
        ST_MEM_WAIT  = 2'd2
    } state_t;

    // One shadow pipeline slot: only the fields that hazard detection needs.
    typedef struct packed {
        logic       valid;
        logic [3:0] dest;
        logic       wb_en;
        logic       is_load;
        logic       is_mem;
    } entry_t;

    entry_t ex_q, ex_d;
    entry_t mem_q, mem_d;
    state_t state_q, state_d;
    logic [7:0] stall_cnt_q, stall_cnt_d;

    logic mem_wait;
    logic hazard;
    logic src1_ex_hit;
    logic src2_ex_hit;

    // A memory-stage access that has not completed freezes everything.
    assign mem_wait = mem_q.valid & mem_q.is_mem & ~mem_ready;

    // Source matches against the EX slot are needed in both hazard modes.
    assign src1_ex_hit = ex_q.valid & ex_q.wb_en & (ex_q.dest == src1);
    assign src2_ex_hit = ex_q.valid & ex_q.wb_en & (ex_q.dest == src2);

    generate
        if (FORWARD_EN != 0) begin : g_fwd
            // With forwarding only a load sitting in EX cannot be bypassed in time.
            assign hazard = id_valid & ex_q.is_load &
                            (src1_ex_hit | (two_src & src2_ex_hit));
        end else begin : g_nofwd
            logic src1_mem_hit;
            logic src2_mem_hit;
            assign src1_mem_hit = mem_q.valid & mem_q.wb_en & (mem_q.dest == src1);
            assign src2_mem_hit = mem_q.valid & mem_q.wb_en & (mem_q.dest == src2);
            // Without forwarding any in-flight producer of a read source stalls ID.
            assign hazard = id_valid &
                            ((src1_ex_hit | src1_mem_hit) |
                             (two_src & (src2_ex_hit | src2_mem_hit)));
        end
    endgenerate

    // Control outputs act in the same cycle; priority is mem_wait, then branch, then hazard.
    assign freeze_pipe  = mem_wait;
    assign flush        = branch_taken & ~mem_wait;
    assign freeze_pc    = mem_wait | (hazard & ~branch_taken);
    assign freeze_if_id = freeze_pc;
    assign bubble_ex    = ~mem_wait & (hazard | branch_taken);

    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;

    // Next shadow contents: hold on memory wait, otherwise advance and admit ID if it issues.
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        if (!mem_wait) begin
            mem_d = ex_q;
            if (id_valid && !hazard && !branch_taken) begin
                ex_d.valid   = 1'b1;
                ex_d.dest    = id_dest;
                ex_d.wb_en   = id_wb_en;
                ex_d.is_load = id_mem_r_en;
                ex_d.is_mem  = id_mem_r_en | id_mem_w_en;
            end else begin
                ex_d.valid = 1'b0;
            end
        end
    end

    // Next FSM state records this cycle's decision; stall counter saturates at 255.
    always_comb begin
        state_d = ST_RUN;
        if (mem_wait) begin
            state_d = ST_MEM_WAIT;
        end else if (hazard && !branch_taken) begin
            state_d = ST_HAZ_STALL;
        end
        stall_cnt_d = stall_cnt_q;
        if (freeze_pc && (stall_cnt_q != 8'hFF)) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    // Shadow pipeline registers; reset empties both slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
        end
    end

    // FSM state and stall counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: one instance with forwarding, one without,
// both driven by the same stimulus. Each scenario task checks only the instance
// whose behaviour it targets (or both where they must agree).
module tb_hazard_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [3:0] src1;
    logic [3:0] src2;
    logic       two_src;
    logic [3:0] id_dest;
    logic       id_wb_en;
    logic       id_mem_r_en;
    logic       id_mem_w_en;
    logic       branch_taken;
    logic       mem_ready;

    logic       fpc1, fifid1, bub1, fpipe1, flush1;
    logic [1:0] state1;
    logic [7:0] cnt1;
    logic       fpc0, fifid0, bub0, fpipe0, flush0;
    logic [1:0] state0;
    logic [7:0] cnt0;

    // Packed views: {freeze_pc, freeze_if_id, bubble_ex, freeze_pipe, flush}
    logic [4:0] o1;
    logic [4:0] o0;
    assign o1 = {fpc1, fifid1, bub1, fpipe1, flush1};
    assign o0 = {fpc0, fifid0, bub0, fpipe0, flush0};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_scheduler #(.FORWARD_EN(1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
        .two_src(two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .freeze_pc(fpc1), .freeze_if_id(fifid1), .bubble_ex(bub1),
        .freeze_pipe(fpipe1), .flush(flush1), .state(state1), .stall_cnt(cnt1)
    );

    hazard_scheduler #(.FORWARD_EN(0)) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
        .two_src(two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .freeze_pc(fpc0), .freeze_if_id(fifid0), .bubble_ex(bub0),
        .freeze_pipe(fpipe0), .flush(flush0), .state(state0), .stall_cnt(cnt0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                          input logic ts, input logic [3:0] d, input logic wb,
                          input logic ld, input logic st);
        id_valid    = v;
        src1        = s1;
        src2        = s2;
        two_src     = ts;
        id_dest     = d;
        id_wb_en    = wb;
        id_mem_r_en = ld;
        id_mem_w_en = st;
    endtask

    task automatic idle();
        set_id(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        branch_taken = 1'b0;
        mem_ready    = 1'b1;
        rst          = 1'b1;
        tick();
        rst = 1'b0;
        #2;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (o1 !== 5'b00000) begin bad++; $display("FAIL reset_out got=%b exp=%b", o1, 5'b00000); end
        total++;
        if (state1 !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", state1, 0); end
        total++;
        if (cnt1 !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=%0d", cnt1, 0); end
        total++;
        if (o0 !== 5'b00000) begin bad++; $display("FAIL reset_out0 got=%b exp=%b", o0, 5'b00000); end
        $display("test_reset: outputs=%b state=%0d cnt=%0d", o1, state1, cnt1);
    endtask

    task automatic test_load_use_fwd();
        do_reset();
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0);   // LW R3
        #2;
        total++;
        if (o1 !== 5'b00000) begin bad++; $display("FAIL lu_issue got=%b exp=%b", o1, 5'b00000); end
        tick();
        set_id(1'b1, 4'd3, 4'd1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0);   // ADD R4,R3,R1
        #2;
        total++;
        if (o1 !== 5'b11100) begin bad++; $display("FAIL lu_stall got=%b exp=%b", o1, 5'b11100); end
        tick();
        #2;
        total++;
        if (state1 !== 2'd1) begin bad++; $display("FAIL lu_state got=%0d exp=%0d", state1, 1); end
        total++;
        if (cnt1 !== 8'd1) begin bad++; $display("FAIL lu_cnt got=%0d exp=%0d", cnt1, 1); end
        total++;
        if (o1 !== 5'b00000) begin bad++; $display("FAIL lu_release got=%b exp=%b", o1, 5'b00000); end
        tick();
        idle();
        #2;
        total++;
        if (state1 !== 2'd0) begin bad++; $display("FAIL lu_state_run got=%0d exp=%0d", state1, 0); end
        total++;
        if (cnt1 !== 8'd1) begin bad++; $display("FAIL lu_cnt_hold got=%0d exp=%0d", cnt1, 1); end
        $display("test_load_use_fwd: state=%0d cnt=%0d", state1, cnt1);
    endtask

    task automatic test_raw_nofwd();
        do_reset();
        set_id(1'b1, 4'd1, 4'd2, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);   // ADD R5
        #2;
        total++;
        if (o0 !== 5'b00000) begin bad++; $display("FAIL raw_issue got=%b exp=%b", o0, 5'b00000); end
        tick();
        set_id(1'b1, 4'd1, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0);   // SUB R6,R1,R5
        #2;
        total++;
        if (o0 !== 5'b11100) begin bad++; $display("FAIL raw_ex_stall got=%b exp=%b", o0, 5'b11100); end
        total++;
        if (o1 !== 5'b00000) begin bad++; $display("FAIL raw_fwd_nostall got=%b exp=%b", o1, 5'b00000); end
        tick();
        #2;
        total++;
        if (o0 !== 5'b11100) begin bad++; $display("FAIL raw_mem_stall got=%b exp=%b", o0, 5'b11100); end
        tick();
        #2;
        total++;
        if (o0 !== 5'b00000) begin bad++; $display("FAIL raw_release got=%b exp=%b", o0, 5'b00000); end
        total++;
        if (cnt0 !== 8'd2) begin bad++; $display("FAIL raw_cnt got=%0d exp=%0d", cnt0, 2); end
        total++;
        if (state0 !== 2'd1) begin bad++; $display("FAIL raw_state got=%0d exp=%0d", state0, 1); end
        $display("test_raw_nofwd two_src=1: cnt=%0d", cnt0);

        do_reset();
        set_id(1'b1, 4'd1, 4'd2, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 4'd1, 4'd5, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0);   // src2 not read
        #2;
        total++;
        if (o0 !== 5'b00000) begin bad++; $display("FAIL raw_1src_a got=%b exp=%b", o0, 5'b00000); end
        tick();
        #2;
        total++;
        if (o0 !== 5'b00000) begin bad++; $display("FAIL raw_1src_b got=%b exp=%b", o0, 5'b00000); end
        total++;
        if (cnt0 !== 8'd0) begin bad++; $display("FAIL raw_1src_cnt got=%0d exp=%0d", cnt0, 0); end
        $display("test_raw_nofwd two_src=0: cnt=%0d", cnt0);
    endtask

    task automatic test_mem_wait();
        do_reset();
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0);   // LW R3
        tick();
        idle();
        tick();                                                    // load now in MEM
        mem_ready = 1'b0;
        set_id(1'b1, 4'd3, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0);   // ADD R7,R3 waiting in ID
        for (int i = 0; i < 4; i++) begin
            #2;
            total++;
            if (o0 !== 5'b11010) begin bad++; $display("FAIL mw_out0[%0d] got=%b exp=%b", i, o0, 5'b11010); end
            total++;
            if (o1 !== 5'b11010) begin bad++; $display("FAIL mw_out1[%0d] got=%b exp=%b", i, o1, 5'b11010); end
            tick();
            total++;
            if (state0 !== 2'd2) begin bad++; $display("FAIL mw_state[%0d] got=%0d exp=%0d", i, state0, 2); end
        end
        total++;
        if (cnt0 !== 8'd4) begin bad++; $display("FAIL mw_cnt got=%0d exp=%0d", cnt0, 4); end
        mem_ready = 1'b1;
        #2;
        // Load still in MEM: no-forward instance now stalls on it, forwarding one does not.
        total++;
        if (o0 !== 5'b11100) begin bad++; $display("FAIL mw_after0 got=%b exp=%b", o0, 5'b11100); end
        total++;
        if (o1 !== 5'b00000) begin bad++; $display("FAIL mw_after1 got=%b exp=%b", o1, 5'b00000); end
        tick();
        total++;
        if (state0 !== 2'd1) begin bad++; $display("FAIL mw_state_haz got=%0d exp=%0d", state0, 1); end
        total++;
        if (cnt0 !== 8'd5) begin bad++; $display("FAIL mw_cnt5 got=%0d exp=%0d", cnt0, 5); end
        $display("test_mem_wait: cnt0=%0d cnt1=%0d", cnt0, cnt1);
    endtask

    task automatic test_branch_priority();
        do_reset();
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0);   // LW R3
        tick();
        set_id(1'b1, 4'd3, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0);   // ADD R4,R3
        branch_taken = 1'b1;
        #2;
        total++;
        if (o1 !== 5'b00101) begin bad++; $display("FAIL br_out got=%b exp=%b", o1, 5'b00101); end
        tick();
        branch_taken = 1'b0;
        idle();
        #2;
        total++;
        if (cnt1 !== 8'd0) begin bad++; $display("FAIL br_cnt got=%0d exp=%0d", cnt1, 0); end
        total++;
        if (state1 !== 2'd0) begin bad++; $display("FAIL br_state got=%0d exp=%0d", state1, 0); end
        $display("test_branch_priority: cnt=%0d state=%0d", cnt1, state1);
    endtask

    task automatic test_reg15_and_invalid();
        do_reset();
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd15, 1'b1, 1'b1, 1'b0);  // LW R15
        tick();
        set_id(1'b0, 4'd15, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);  // not a real instruction
        #2;
        total++;
        if (o1 !== 5'b00000) begin bad++; $display("FAIL r15_invalid got=%b exp=%b", o1, 5'b00000); end
        set_id(1'b1, 4'd0, 4'd15, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);  // src2 = R15
        #2;
        total++;
        if (o1 !== 5'b11100) begin bad++; $display("FAIL r15_src2 got=%b exp=%b", o1, 5'b11100); end
        two_src = 1'b0;
        #2;
        total++;
        if (o1 !== 5'b00000) begin bad++; $display("FAIL r15_src2_unused got=%b exp=%b", o1, 5'b00000); end
        $display("test_reg15_and_invalid: outputs=%b", o1);
    endtask

    task automatic test_saturate_and_reset();
        do_reset();
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        mem_ready = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 254) begin
                total++;
                if (cnt1 !== 8'd254) begin bad++; $display("FAIL sat_254 got=%0d exp=%0d", cnt1, 254); end
            end
            if (i == 255) begin
                total++;
                if (cnt1 !== 8'd255) begin bad++; $display("FAIL sat_255 got=%0d exp=%0d", cnt1, 255); end
            end
        end
        total++;
        if (cnt1 !== 8'd255) begin bad++; $display("FAIL sat_hold got=%0d exp=%0d", cnt1, 255); end
        total++;
        if (cnt0 !== 8'd255) begin bad++; $display("FAIL sat_hold0 got=%0d exp=%0d", cnt0, 255); end
        total++;
        if (state1 !== 2'd2) begin bad++; $display("FAIL sat_state got=%0d exp=%0d", state1, 2); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        // mem_ready still low: only an emptied shadow keeps freeze_pipe low.
        total++;
        if (cnt1 !== 8'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=%0d", cnt1, 0); end
        total++;
        if (state1 !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", state1, 0); end
        total++;
        if (o1 !== 5'b00000) begin bad++; $display("FAIL rst_shadow got=%b exp=%b", o1, 5'b00000); end
        mem_ready = 1'b1;
        $display("test_saturate_and_reset: cnt=%0d state=%0d", cnt1, state1);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        branch_taken = 1'b0;
        mem_ready    = 1'b1;
        tick();
        test_reset();
        test_load_use_fwd();
        test_raw_nofwd();
        test_mem_wait();
        test_branch_priority();
        test_reg15_and_invalid();
        test_saturate_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
